rns_ohc7_add_sched: RTL
=======================

# rns_ohc7_add_sched

Shared-resource scheduler for the mod-7 one-hot residue adder in the RNS modulo-adder datapath. It accepts binary residue-operand pairs from N_REQ requesters and grants them round-robin. The granted pair is converted to 7-bit one-hot code, and the sum is formed by iterative one-hot rotation. Each result is returned to the granted requester through a valid/ready response port tagged with the requester ID.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of requester ID
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand pair valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle
- req_a  in  N_REQ*3  binary residue A per requester, slice i = [3i+2:3i]
- req_b  in  N_REQ*3  binary residue B per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  ID_W  requester that owns the result
- rsp_sum  out  3  binary sum (A+B) mod 7
- rsp_sum_oh  out  7  one-hot sum, bit r set for residue r
- rsp_err  out  1  invalid operand flag (see Configuration)
- busy  out  1  high in any state other than IDLE

## Operation
- One-hot code: residue r (0..6) maps to 7'b1 << r. Binary 3'b111 is not a valid residue.
- FSM states: IDLE, ROT, RESP.
- IDLE:
  - If any req_valid is high, g = the first requester with req_valid high, searching upward from rr_ptr with wrap.
  - req_ready[g] = 1 combinationally in this cycle.
  - On the clock edge: acc <= onehot(req_a[g]), cnt <= req_b[g], id <= g, rr_ptr <= (g+1) mod N_REQ, next state ROT.
- ROT:
  - If cnt == 0, next state RESP.
  - Otherwise acc <= {acc[5:0], acc[6]} (rotate left by 1) and cnt <= cnt-1.
- RESP:
  - rsp_valid = 1. rsp_sum_oh = acc, rsp_sum = binary(acc), rsp_id = id.
  - Outputs are held stable until rsp_ready. On rsp_valid & rsp_ready, next state IDLE.
- req_ready is 0 outside IDLE. A requester keeps req_valid and its operands stable until it sees req_ready.
- Round-robin is work-conserving. A requester that just won has lowest priority next time.
- Reset values: state IDLE, rr_ptr 0, acc 0, cnt 0, id 0. All outputs are 0: req_ready, rsp_valid, rsp_sum, rsp_sum_oh, rsp_id, rsp_err, busy.
- Reset mid-operation: the in-flight request is discarded without a response. The requester already saw its handshake and must reissue it.
- rst has priority over every handshake in the same cycle.

## Timing
- The accept cycle is t (IDLE, req_valid & req_ready).
- rsp_valid first rises at t+2+b, where b is the B operand: 0..6, or 0 for an invalid operand with RNS_OHC_ERR_EN.
- Minimum latency is 2 (b=0). Maximum latency is 8 (b=6).
- A response handshake at cycle u puts the FSM in IDLE at u+1. The earliest next accept is u+1.
- Throughput is one operation per 3+b cycles with no backpressure.
- Backpressure: RESP is held indefinitely, with outputs constant.

## Configuration
- Macro: RNS_OHC_ERR_EN.
- Defined:
  - An operand equal to 3'b111 sets an err register at accept.
  - In that case acc <= 0, cnt <= 0, and in RESP: rsp_err = 1, rsp_sum_oh = 7'b0, rsp_sum = 3'b0.
- Undefined:
  - 3'b111 is reduced mod 7, i.e. treated as residue 0.
  - rsp_err is tied to 0 and no err register exists.

## Structure
- Package rns_pkg holds:
  - constants RNS_MOD = 7, RES_W = 3, OH_W = 7;
  - the state enum {IDLE, ROT, RESP};
  - the function oh7_to_bin.
- Sub-module rns_bin2ohc7 (3-bit binary in, 7-bit one-hot out, 3'b111 → 0) performs the operand conversion. It is instantiated once on the muxed req_a[g].

## Test plan
- Reset, then req0: a=3, b=5 → accept at t. rsp_valid at t+7 with rsp_sum=1, rsp_sum_oh=7'b0000010, rsp_id=0.
- req1: a=4, b=0 → rsp_valid at t+2 with rsp_sum=4, rsp_sum_oh=7'b0010000.
- req0 and req2 valid together after reset → req0 granted first, then req2. With req0 re-asserted, the order is req2 before the second req0.
- rsp_ready held low for 10 cycles in RESP → rsp_valid stays 1 with constant outputs, req_ready stays 0 throughout, busy=1. Releasing rsp_ready gives IDLE the next cycle.
- a=6, b=7:
  - with RNS_OHC_ERR_EN: rsp_err=1, rsp_sum_oh=0, latency 2;
  - without it: rsp_sum=6, rsp_err=0.
- rst asserted during ROT (a=1, b=6, third ROT cycle) → next cycle IDLE, all outputs 0, and no response is ever produced for that request.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared constants, FSM state type and one-hot decode for the mod-7 adder.
// Used by the scheduler and the binary to one-hot converter.
package rns_pkg;

    localparam int RNS_MOD = 7;
    localparam int RES_W   = 3;
    localparam int OH_W    = 7;

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        RESP
    } state_t;

    function automatic logic [RES_W-1:0] oh7_to_bin(input logic [OH_W-1:0] oh);
        logic [RES_W-1:0] b;
        b = '0;
        for (int i = 0; i < OH_W; i++) begin
            if (oh[i]) b = RES_W'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rns_bin2ohc7.sv
// Binary residue to 7-bit one-hot code; 3'b111 folds to residue 0.
module rns_bin2ohc7
    import rns_pkg::*;
(
    input  logic [RES_W-1:0] bin,
    output logic [OH_W-1:0]  oh
);

    assign oh = (bin == 3'd7) ? 7'd1 : (7'd1 << bin);

endmodule

// File: rtl/rns_ohc7_add_sched.sv
// Round-robin scheduler for a shared one-hot mod-7 rotation adder.
// Optional macro RNS_OHC_ERR_EN flags 3'b111 operands instead of folding them.
module rns_ohc7_add_sched
    import rns_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*3-1:0] req_a,
    input  logic [N_REQ*3-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [RES_W-1:0]   rsp_sum,
    output logic [OH_W-1:0]    rsp_sum_oh,
    output logic               rsp_err,
    output logic               busy
);

    state_t            state;
    state_t            nstate;
    logic [OH_W-1:0]   acc;
    logic [RES_W-1:0]  cnt;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt;
    logic              found;
    int                scan;
    logic [RES_W-1:0]  a_sel;
    logic [RES_W-1:0]  b_sel;
    logic [OH_W-1:0]   a_oh;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        scan  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= N_REQ) scan = scan - N_REQ;
            if (!found && req_valid[scan]) begin
                found = 1'b1;
                gnt   = ID_W'(scan);
            end
        end
    end

    assign a_sel = req_a[RES_W*gnt +: RES_W];
    assign b_sel = req_b[RES_W*gnt +: RES_W];

    rns_bin2ohc7 u_conv (
        .bin (a_sel),
        .oh  (a_oh)
    );

`ifdef RNS_OHC_ERR_EN
    logic err;
    logic bad;
    assign bad = (a_sel == 3'd7) || (b_sel == 3'd7);
`else
    logic [RES_W-1:0] b_mod;
    assign b_mod = (b_sel == 3'd7) ? 3'd0 : b_sel;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (found)      nstate = ROT;
            ROT:     if (cnt == '0)  nstate = RESP;
            RESP:    if (rsp_ready)  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            id     <= '0;
            rr_ptr <= '0;
`ifdef RNS_OHC_ERR_EN
            err    <= 1'b0;
`endif
        end else if (state == IDLE && found) begin
            id     <= gnt;
            rr_ptr <= (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + ID_W'(1);
`ifdef RNS_OHC_ERR_EN
            err    <= bad;
            acc    <= bad ? '0 : a_oh;
            cnt    <= bad ? '0 : b_sel;
`else
            acc    <= a_oh;
            cnt    <= b_mod;
`endif
        end else if (state == ROT && cnt != '0) begin
            acc <= {acc[5:0], acc[6]};
            cnt <= cnt - 3'd1;
        end
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = (state == RESP);
        rsp_sum_oh = '0;
        rsp_sum    = '0;
        rsp_id     = '0;
        busy       = (state != IDLE);
        if (state == IDLE && found && !rst) req_ready[gnt] = 1'b1;
        if (state == RESP) begin
            rsp_sum_oh = acc;
            rsp_sum    = oh7_to_bin(acc);
            rsp_id     = id;
        end
    end

`ifdef RNS_OHC_ERR_EN
    assign rsp_err = (state == RESP) && err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
